acc8_burst_accum: RTL and testbench



---
 rtl/acc8_burst_accum.sv | 137 +++++++++++++
 tb/tb_acc8_burst_accum.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc8_burst_accum.sv
// rtl/acc8_burst_accum.sv - 8-bit burst accumulator over a ripple adder; define ACC8_SATURATE_EN to clamp at 0xFF

// Combinational 8-bit ripple-carry adder: sum_o/co_o = a_i + b_i + ci_i.
module acc8_ripple_add (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       ci_i,
  output logic [7:0] sum_o,
  output logic       co_o
);

  logic [8:0] c;

  assign c[0] = ci_i;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign co_o = c[8];

endmodule

// Collects a burst of operand beats into an accumulator and presents the
// total, a sticky carry flag and a saturating beat count downstream.
module acc8_burst_accum #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [7:0]       acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [7:0] nsum;
  logic       nco;
  logic       accept;
  logic       ovf_next;

  // acc is held at zero outside a burst, so the first beat passes through as 0 + in_data
  acc8_ripple_add u_add (
    .a_i   (acc_q),
    .b_i   (in_data),
    .ci_i  (1'b0),
    .sum_o (nsum),
    .co_o  (nco)
  );

  assign in_ready = (state_q != S_HOLD);
  assign accept   = in_valid && in_ready;
  assign ovf_next = ovf_q | nco;

  // Next-state logic: accumulate beats, hold the result until it is taken
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d   = nsum;
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(1);
          state_d = in_last ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept) begin
`ifdef ACC8_SATURATE_EN
          // Once any carry has been seen the burst total is pinned at full scale
          acc_d = ovf_next ? 8'hFF : nsum;
`else
          acc_d = nsum;
`endif
          ovf_d   = ovf_next;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          state_d = in_last ? S_HOLD : S_ACCUM;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          acc_d   = 8'h00;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        acc_d   = 8'h00;
        ovf_d   = 1'b0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset discards any partial burst or pending result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= 8'h00;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == S_HOLD);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_acc8_burst_accum.sv
// tb/tb_acc8_burst_accum.sv - directed scoreboard bench for acc8_burst_accum

module tb_acc8_burst_accum;

  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef struct packed {
    logic [7:0]       sum;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  int n_cmp = 0;
  int n_err = 0;

  exp_t exp_q[$];

  logic [7:0]       m_acc = 8'h00;
  logic             m_ovf = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;

  acc8_burst_accum #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_acc = 8'h00;
    m_ovf = 1'b0;
    m_cnt = '0;
  endtask

  // Updates the reference model, pushes the expected result on the last beat,
  // then drives the beat until it is accepted. waits = cycles spent blocked.
  task automatic beat(input logic [7:0] d, input logic last, output int waits);
    logic [8:0] s;
    exp_t e;
    s = {1'b0, m_acc} + {1'b0, d};
    m_ovf = m_ovf | s[8];
`ifdef ACC8_SATURATE_EN
    m_acc = m_ovf ? 8'hFF : s[7:0];
`else
    m_acc = s[7:0];
`endif
    if (m_cnt != CMAX) m_cnt = m_cnt + CNT_W'(1);
    if (last) begin
      e.sum = m_acc;
      e.ovf = m_ovf;
      e.cnt = m_cnt;
      exp_q.push_back(e);
      model_clear();
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    waits = 0;
    while (!in_ready && waits < 20) begin
      @(posedge clk);
      #1;
      waits++;
    end
    check("accept_timeout", 32'(waits < 20), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(in_ready && !out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_timeout", 32'(n < 50), 32'd1);
  endtask

  // Scoreboard: every result handshake pops and compares one expected burst
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_sum", 32'(out_sum), 32'(e.sum));
        check("out_ovf", 32'(out_ovf), 32'(e.ovf));
        check("out_count", 32'(out_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    int w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'h00);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    rst = 1'b0;

    // Basic burst with latency check
    beat(8'h10, 1'b0, w);
    beat(8'h20, 1'b0, w);
    check("basic_not_valid_early", 32'(out_valid), 32'd0);
    beat(8'h05, 1'b1, w);
    check("basic_latency", 32'(out_valid), 32'd1);
    wait_idle();

    // Overflow burst
    beat(8'hF0, 1'b0, w);
    beat(8'h20, 1'b1, w);
    wait_idle();

    // Backpressure: result held 5 cycles, input ignored while held
    out_ready = 1'b0;
    beat(8'h01, 1'b1, w);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_sum", 32'(out_sum), 32'h01);
      check("bp_out_ovf", 32'(out_ovf), 32'd0);
      check("bp_out_count", 32'(out_count), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Stall mid-burst and count saturation at 3
    beat(8'h01, 1'b0, w);
    beat(8'h01, 1'b0, w);
    repeat (2) @(posedge clk);
    #1;
    check("stall_in_ready", 32'(in_ready), 32'd1);
    check("stall_out_valid", 32'(out_valid), 32'd0);
    beat(8'h01, 1'b0, w);
    beat(8'h01, 1'b0, w);
    beat(8'h01, 1'b1, w);
    wait_idle();

    // Reset mid-burst discards the partial burst
    beat(8'h40, 1'b0, w);
    beat(8'h40, 1'b0, w);
    model_clear();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_sum", 32'(out_sum), 32'h00);
    check("midrst_out_count", 32'(out_count), 32'd0);
    beat(8'h07, 1'b1, w);
    wait_idle();

    // Back-to-back bursts: one bubble between them
    beat(8'hFF, 1'b0, w);
    beat(8'h01, 1'b1, w);
    beat(8'h02, 1'b1, w);
    check("b2b_bubble", 32'(w), 32'd1);
    check("b2b_second_valid", 32'(out_valid), 32'd1);
    wait_idle();

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("final_out_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
